// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle around alu_cmd_sequencer: byte stream in, ALU operands/result, result bytes out.
// master is the sequencer; slave is the front end, ALU and result sink seen from outside.
interface alu_cmd_sequencer_if;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VALID;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic        DONE;
    logic        CMD_ERR;
    logic        OVERRUN;

    modport master (
        input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
        output ALU_FUN, ALU_A, ALU_B, TX_DATA, TX_VALID, BUSY, DONE, CMD_ERR, OVERRUN
    );

    modport slave (
        output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
        input  ALU_FUN, ALU_A, ALU_B, TX_DATA, TX_VALID, BUSY, DONE, CMD_ERR, OVERRUN
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU initiator: assembles a 5-byte command frame (fun, A_lo, A_hi, B_lo, B_hi), issues it
// to the ALU, captures the result and returns it as two bytes, low byte first.
//
// state   | meaning
// IDLE    | waiting for a function byte
// GET_AL  | waiting for operand A low byte
// GET_AH  | waiting for operand A high byte
// GET_BL  | waiting for operand B low byte
// GET_BH  | waiting for operand B high byte
// ISSUE   | operands stable, ALU registers them at the closing edge
// WAIT    | waiting for ALU_OUT_VALID
// SEND_LO | offering result[7:0]
// SEND_HI | offering result[15:8]
module alu_cmd_sequencer #(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [3:0] BAD_FUN     = 4'hF
) (
    input  logic CLK,
    input  logic RST,
    alu_cmd_sequencer_if.master bus
);
    localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, GET_AL, GET_AH, GET_BL, GET_BH, ISSUE, WAIT, SEND_LO, SEND_HI
    } state_t;

    state_t state, state_nxt;

    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [3:0]  alu_fun;
    logic [15:0] alu_a, alu_b, result;
    logic        done_q, cmd_err_q, overrun_q;
    logic        ld_fun, ld_al, ld_ah, ld_bl, ld_bh, ld_result;
    logic        bad_fun, timeout, done_set, timed_state, busy, tx_valid, tmo_hit;
    logic [7:0]  tx_data;

    assign tmo_hit = (timer == TIMER_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ld_fun      = 1'b0;
        ld_al       = 1'b0;
        ld_ah       = 1'b0;
        ld_bl       = 1'b0;
        ld_bh       = 1'b0;
        ld_result   = 1'b0;
        bad_fun     = 1'b0;
        timeout     = 1'b0;
        done_set    = 1'b0;
        timed_state = 1'b0;
        busy        = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (state)
            IDLE: begin
                if (bus.RX_VALID) begin
                    if (bus.RX_DATA[3:0] == BAD_FUN) begin
                        bad_fun = 1'b1;
                    end else begin
                        ld_fun    = 1'b1;
                        state_nxt = GET_AL;
                    end
                end
            end
            GET_AL, GET_AH, GET_BL, GET_BH: begin
                timed_state = 1'b1;
                if (bus.RX_VALID) begin
                    case (state)
                        GET_AL:  begin ld_al = 1'b1; state_nxt = GET_AH; end
                        GET_AH:  begin ld_ah = 1'b1; state_nxt = GET_BL; end
                        GET_BL:  begin ld_bl = 1'b1; state_nxt = GET_BH; end
                        default: begin ld_bh = 1'b1; state_nxt = ISSUE;  end
                    endcase
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy        = 1'b1;
                timed_state = 1'b1;
                if (bus.ALU_OUT_VALID) begin
                    ld_result = 1'b1;
                    state_nxt = SEND_LO;
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND_LO: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = result[7:0];
                if (bus.TX_READY) state_nxt = SEND_HI;
            end
            SEND_HI: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = result[15:8];
                if (bus.TX_READY) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every accepted byte changes state, so a state change alone restarts the idle timer.
    always_comb begin
        timer_nxt = '0;
        if (timed_state && (state_nxt == state)) timer_nxt = timer + TIMER_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer     <= '0;
            alu_fun   <= 4'h0;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            result    <= 16'h0000;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            timer <= timer_nxt;
            if (ld_fun)    alu_fun     <= bus.RX_DATA[3:0];
            if (ld_al)     alu_a[7:0]  <= bus.RX_DATA;
            if (ld_ah)     alu_a[15:8] <= bus.RX_DATA;
            if (ld_bl)     alu_b[7:0]  <= bus.RX_DATA;
            if (ld_bh)     alu_b[15:8] <= bus.RX_DATA;
            if (ld_result) result      <= bus.ALU_OUT;
            done_q    <= done_set;
            cmd_err_q <= bad_fun | timeout;
            overrun_q <= busy & bus.RX_VALID;
        end
    end

    assign bus.ALU_FUN  = alu_fun;
    assign bus.ALU_A    = alu_a;
    assign bus.ALU_B    = alu_b;
    assign bus.TX_DATA  = tx_data;
    assign bus.TX_VALID = tx_valid;
    assign bus.BUSY     = busy;
    assign bus.DONE     = done_q;
    assign bus.CMD_ERR  = cmd_err_q;
    assign bus.OVERRUN  = overrun_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed frames plus randomized frames with random gaps,
// backpressure and stray bytes, checked against a frame-level model and a simple ALU responder.
module tb_alu_cmd_sequencer;
    localparam int         TIMEOUT_CYC = 1024;
    localparam logic [3:0] BAD_FUN     = 4'hF;

    logic CLK = 1'b0;
    logic RST;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .BAD_FUN(BAD_FUN)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Last successfully started frame, as the bench understands it.
    logic [3:0]  model_fun;
    logic [15:0] model_a, model_b;

    function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return 16'(a * b);
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            4'h6:    return a << b[3:0];
            4'h7:    return a >> b[3:0];
            default: return a + b + 16'(f);
        endcase
    endfunction

    // ALU responder: captures operands at the edge closing ISSUE, answers one cycle later.
    logic        alu_hold;
    logic        alu_pend, busy_q;
    logic [3:0]  alu_f_q;
    logic [15:0] alu_a_q, alu_b_q;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q            <= 1'b0;
            alu_pend          <= 1'b0;
            alu_f_q           <= 4'h0;
            alu_a_q           <= 16'h0;
            alu_b_q           <= 16'h0;
            bus.ALU_OUT       <= 16'h0;
            bus.ALU_OUT_VALID <= 1'b0;
        end else begin
            busy_q            <= bus.BUSY;
            bus.ALU_OUT_VALID <= 1'b0;
            alu_pend          <= 1'b0;
            if (bus.BUSY && !busy_q && !alu_hold) begin
                alu_f_q  <= bus.ALU_FUN;
                alu_a_q  <= bus.ALU_A;
                alu_b_q  <= bus.ALU_B;
                alu_pend <= 1'b1;
            end
            if (alu_pend) begin
                bus.ALU_OUT       <= alu_fn(alu_f_q, alu_a_q, alu_b_q);
                bus.ALU_OUT_VALID <= 1'b1;
            end
        end
    end

    // Observer: counts pulses, records accepted TX bytes, watches TX hold-while-stalled.
    int done_cnt = 0, err_cnt = 0, ovr_cnt = 0, hold_errs = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] tx_q[$];
    always begin
        @(negedge CLK);
        #3;
        if (bus.DONE === 1'b1)    done_cnt++;
        if (bus.CMD_ERR === 1'b1) err_cnt++;
        if (bus.OVERRUN === 1'b1) ovr_cnt++;
        if (bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) tx_q.push_back(bus.TX_DATA);
        if (hold_pend && (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== hold_data)) hold_errs++;
        hold_pend = (bus.TX_VALID === 1'b1 && bus.TX_READY !== 1'b1);
        hold_data = bus.TX_DATA;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.RX_VALID = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] f, input logic [15:0] a, input logic [15:0] b, input int max_gap);
        send_byte(f);
        idle_cycles($urandom_range(0, max_gap));
        send_byte(a[7:0]);
        idle_cycles($urandom_range(0, max_gap));
        send_byte(a[15:8]);
        idle_cycles($urandom_range(0, max_gap));
        send_byte(b[7:0]);
        idle_cycles($urandom_range(0, max_gap));
        send_byte(b[15:8]);
    endtask

    // Drives TX_READY and stray RX bytes until nbytes more result bytes have been accepted.
    task automatic collect_result(input int nbytes, input int ready_pct, input int spur_pct,
                                  output int nspur, output logic ok);
        int target;
        target = tx_q.size() + nbytes;
        nspur  = 0;
        ok     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            bus.TX_READY = ($urandom_range(0, 99) < ready_pct);
            bus.RX_VALID = ($urandom_range(0, 99) < spur_pct);
            bus.RX_DATA  = 8'($urandom);
            if (bus.RX_VALID) nspur++;
            #4;
            if (tx_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
        bus.TX_READY = 1'b0;
        #4;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        checks++; if (bus.BUSY !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.TX_VALID !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.TX_VALID); end
        checks++; if (bus.TX_DATA !== 8'h00)  begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.TX_DATA); end
        checks++; if ({bus.DONE, bus.CMD_ERR, bus.OVERRUN} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {bus.DONE, bus.CMD_ERR, bus.OVERRUN}); end
        checks++; if ({bus.ALU_FUN, bus.ALU_A, bus.ALU_B} !== 36'h0) begin errors++; $display("FAIL reset_alu: got %h expected 0", {bus.ALU_FUN, bus.ALU_A, bus.ALU_B}); end
        @(negedge CLK);
        RST = 1'b0;
        model_fun = 4'h0;
        model_a   = 16'h0;
        model_b   = 16'h0;
        idle_cycles(2);
    endtask

    task automatic test_add();
        int q0, d0, nspur;
        logic ok;
        q0 = tx_q.size();
        d0 = done_cnt;
        send_frame(8'h00, 16'h1234, 16'h0001, 0);
        collect_result(2, 100, 0, nspur, ok);
        model_fun = 4'h0; model_a = 16'h1234; model_b = 16'h0001;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_timeout: got no result expected 2 bytes"); end
        if (ok) begin
            checks++; if (tx_q[q0] !== 8'h35)   begin errors++; $display("FAIL add_lo: got %h expected 35", tx_q[q0]); end
            checks++; if (tx_q[q0+1] !== 8'h12) begin errors++; $display("FAIL add_hi: got %h expected 12", tx_q[q0+1]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL add_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        int q0, lat, nspur;
        logic ok;
        q0  = tx_q.size();
        lat = 0;
        send_frame(8'h02, 16'h0003, 16'h0004, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            bus.RX_VALID = 1'b0;
            bus.TX_READY = 1'b0;
            #4;
            if (bus.TX_VALID === 1'b1) begin
                lat = i;
                break;
            end
        end
        // B_hi sampled at the edge after the send negedge; TX_VALID rises 3 edges later.
        checks++; if (lat !== 4) begin errors++; $display("FAIL latency: got %0d expected 4", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.TX_READY = 1'b0;
            #4;
            checks++; if ({bus.TX_VALID, bus.TX_DATA} !== {1'b1, 8'h0C}) begin errors++; $display("FAIL stall_hold: got %b/%h expected 1/0c", bus.TX_VALID, bus.TX_DATA); end
        end
        collect_result(2, 100, 0, nspur, ok);
        model_fun = 4'h2; model_a = 16'h0003; model_b = 16'h0004;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got no result expected 2 bytes"); end
        if (ok) begin
            checks++; if ({tx_q[q0], tx_q[q0+1]} !== 16'h0C00) begin errors++; $display("FAIL bp_bytes: got %h %h expected 0c 00", tx_q[q0], tx_q[q0+1]); end
        end
        checks++; if (hold_errs !== 0) begin errors++; $display("FAIL bp_hold_viol: got %0d expected 0", hold_errs); end
    endtask

    task automatic test_bad_fun();
        int e0, q0, nspur;
        logic ok;
        e0 = err_cnt;
        send_byte(8'h0F);
        idle_cycles(2);
        #4;
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_fun_err: got %0d pulses expected 1", err_cnt - e0); end
        checks++; if (bus.ALU_FUN !== model_fun) begin errors++; $display("FAIL bad_fun_hold: got %h expected %h", bus.ALU_FUN, model_fun); end
        q0 = tx_q.size();
        send_frame(8'h01, 16'h0005, 16'h0002, 0);
        collect_result(2, 100, 0, nspur, ok);
        model_fun = 4'h1; model_a = 16'h0005; model_b = 16'h0002;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bad_fun_next_timeout: got no result expected 2 bytes"); end
        if (ok) begin
            checks++; if ({tx_q[q0], tx_q[q0+1]} !== 16'h0300) begin errors++; $display("FAIL bad_fun_next: got %h %h expected 03 00", tx_q[q0], tx_q[q0+1]); end
        end
    endtask

    task automatic test_timeout();
        int e0, q0, nspur;
        logic ok;
        e0 = err_cnt;
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        idle_cycles(TIMEOUT_CYC);
        #4;
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL timeout_early: got %0d pulses expected 0", err_cnt - e0); end
        idle_cycles(1);
        #4;
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses expected 1", err_cnt - e0); end
        idle_cycles(3);
        #4;
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_width: got %0d pulses expected 1", err_cnt - e0); end
        q0 = tx_q.size();
        send_frame(8'h04, 16'h00F0, 16'h0F0F, 0);
        collect_result(2, 100, 0, nspur, ok);
        model_fun = 4'h4; model_a = 16'h00F0; model_b = 16'h0F0F;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout_next_timeout: got no result expected 2 bytes"); end
        if (ok) begin
            checks++; if ({tx_q[q0], tx_q[q0+1]} !== 16'hFF0F) begin errors++; $display("FAIL timeout_next: got %h %h expected ff 0f", tx_q[q0], tx_q[q0+1]); end
        end
        checks++; if (bus.ALU_A !== 16'h00F0) begin errors++; $display("FAIL timeout_a_reload: got %h expected 00f0", bus.ALU_A); end
    endtask

    task automatic test_overrun();
        int q0, d0, o0, nspur;
        logic ok;
        logic [15:0] a, b, r;
        a  = 16'($urandom);
        b  = 16'($urandom);
        r  = alu_fn(4'h0, a, b);
        q0 = tx_q.size();
        d0 = done_cnt;
        send_frame(8'h00, a, b, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            bus.RX_VALID = 1'b0;
            bus.TX_READY = 1'b0;
            #4;
            if (bus.TX_VALID === 1'b1) break;
        end
        @(negedge CLK);
        bus.TX_READY = 1'b1;
        @(negedge CLK);
        bus.TX_READY = 1'b0;
        o0 = ovr_cnt;
        @(negedge CLK);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = 8'hA5;
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
        #4;
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ovr_cnt - o0); end
        checks++; if ({bus.TX_VALID, bus.TX_DATA} !== {1'b1, r[15:8]}) begin errors++; $display("FAIL overrun_tx: got %b/%h expected 1/%h", bus.TX_VALID, bus.TX_DATA, r[15:8]); end
        collect_result(1, 100, 0, nspur, ok);
        model_fun = 4'h0; model_a = a; model_b = b;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL overrun_timeout: got no result expected 1 byte"); end
        if (ok) begin
            checks++; if ({tx_q[q0], tx_q[q0+1]} !== {r[7:0], r[15:8]}) begin errors++; $display("FAIL overrun_bytes: got %h %h expected %h %h", tx_q[q0], tx_q[q0+1], r[7:0], r[15:8]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL overrun_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (bus.ALU_A !== a) begin errors++; $display("FAIL overrun_a: got %h expected %h", bus.ALU_A, a); end
    endtask

    task automatic test_random_frames();
        int q0, d0, e0, o0, nspur;
        logic ok;
        logic [7:0]  fbyte;
        logic [15:0] a, b, r;
        for (int n = 0; n < 24; n++) begin
            fbyte = 8'($urandom);
            if ($urandom_range(0, 5) == 0) fbyte[3:0] = BAD_FUN;
            e0 = err_cnt;
            d0 = done_cnt;
            o0 = ovr_cnt;
            q0 = tx_q.size();
            if (fbyte[3:0] == BAD_FUN) begin
                send_byte(fbyte);
                idle_cycles(2);
                #4;
                checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL rnd_bad_err %0d: got %0d expected 1", n, err_cnt - e0); end
                checks++; if (bus.ALU_FUN !== model_fun) begin errors++; $display("FAIL rnd_bad_fun %0d: got %h expected %h", n, bus.ALU_FUN, model_fun); end
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
                send_frame(fbyte, a, b, 3);
                collect_result(2, $urandom_range(30, 100), $urandom_range(0, 40), nspur, ok);
                model_fun = fbyte[3:0]; model_a = a; model_b = b;
                r = alu_fn(model_fun, a, b);
                checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_timeout %0d: got no result expected 2 bytes", n); end
                if (ok) begin
                    checks++; if ({tx_q[q0], tx_q[q0+1]} !== {r[7:0], r[15:8]}) begin errors++; $display("FAIL rnd_bytes %0d: got %h %h expected %h %h", n, tx_q[q0], tx_q[q0+1], r[7:0], r[15:8]); end
                end
                checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rnd_done %0d: got %0d expected 1", n, done_cnt - d0); end
                checks++; if (ovr_cnt - o0 !== nspur) begin errors++; $display("FAIL rnd_overrun %0d: got %0d expected %0d", n, ovr_cnt - o0, nspur); end
                checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rnd_err %0d: got %0d expected 0", n, err_cnt - e0); end
                checks++; if ({bus.ALU_FUN, bus.ALU_A, bus.ALU_B} !== {model_fun, a, b}) begin errors++; $display("FAIL rnd_alu_hold %0d: got %h expected %h", n, {bus.ALU_FUN, bus.ALU_A, bus.ALU_B}, {model_fun, a, b}); end
            end
        end
        checks++; if (hold_errs !== 0) begin errors++; $display("FAIL rnd_hold_viol: got %0d expected 0", hold_errs); end
    endtask

    task automatic test_reset_in_wait();
        int q0, nspur;
        logic ok;
        alu_hold = 1'b1;
        send_frame(8'h05, 16'hBEEF, 16'h1234, 0);
        idle_cycles(3);
        #1;
        checks++; if ({bus.BUSY, bus.TX_VALID} !== 2'b10) begin errors++; $display("FAIL rst_wait_pre: got %b expected 10", {bus.BUSY, bus.TX_VALID}); end
        RST = 1'b1;
        #1;
        checks++; if ({bus.BUSY, bus.TX_VALID} !== 2'b00) begin errors++; $display("FAIL rst_wait_async: got %b expected 00", {bus.BUSY, bus.TX_VALID}); end
        checks++; if ({bus.ALU_FUN, bus.ALU_A, bus.ALU_B} !== 36'h0) begin errors++; $display("FAIL rst_wait_alu: got %h expected 0", {bus.ALU_FUN, bus.ALU_A, bus.ALU_B}); end
        idle_cycles(2);
        RST      = 1'b0;
        alu_hold = 1'b0;
        idle_cycles(2);
        q0 = tx_q.size();
        send_frame(8'h03, 16'hF0F0, 16'h3C3C, 1);
        collect_result(2, 70, 0, nspur, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_wait_next_timeout: got no result expected 2 bytes"); end
        if (ok) begin
            checks++; if ({tx_q[q0], tx_q[q0+1]} !== 16'h3030) begin errors++; $display("FAIL rst_wait_next: got %h %h expected 30 30", tx_q[q0], tx_q[q0+1]); end
        end
    endtask

    initial begin
        RST          = 1'b1;
        alu_hold     = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        bus.TX_READY = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_bad_fun();
        test_timeout();
        test_overrun();
        test_random_frames();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before limit");
        $fatal(1, "watchdog expired");
    end
endmodule
